// File: rtl/ctrl_filtro_pa200.sv
// ctrl_filtro_pa200
//   Sequencer for the 200 Hz high-pass biquad datapath. Each accepted start
//   runs a fixed six-step microprogram on the MAC (dato1*dato2 + dato3):
//     f(k) = u(k) - a1*f(k-1) - a2*f(k-2)
//     y(k) = b0*f(k) + b1*f(k-1) + b2*f(k-2), b2 = b0
//   Every step holds its selects for STEP_CYCLES cycles and pulses its
//   register enable only in the last of those cycles.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   start    in   new sample valid on UK (one-cycle pulse)
//   busy     out  computation in progress (state != IDLE)
//   done     out  one-cycle pulse, YK holds the final y(k)
//   overrun  out  one-cycle pulse, a start was ignored while not IDLE
//   muxS     out  dato1 select: 0=Uk 1=fk 2=fk1 3=fk2 4=yk
//   muxC     out  coefficient select: 0=-a1 1=-a2 2=b0(=b2) 3=b1
//   muxZ     out  dato3 select: 0=zero 1=Uk 2=fk 3=yk
//   en1      out  Y(K) register load
//   en2      out  F(K) register load
//   en3      out  F(K-1) load from fk
//   en4      out  F(K-2) load from fk1
module ctrl_filtro_pa200 #(
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic [2:0] muxS,
  output logic [1:0] muxC,
  output logic [1:0] muxZ,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  output logic       en4
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_F1    = 3'd2,
    ST_F2    = 3'd3,
    ST_Y1    = 3'd4,
    ST_Y2    = 3'd5,
    ST_Y3    = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [2:0] mux_s;
    logic [1:0] mux_c;
    logic [1:0] mux_z;
    logic       en1;
    logic       en2;
    logic       en3;
    logic       en4;
  } ctrl_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  ctrl_t            ctrl_q;
  logic             overrun_q;

  state_t           state_nx;
  logic [CNT_W-1:0] cnt_nx;

  // State sequence; step states advance only when their hold count expires.
  function automatic state_t next_state(input state_t s, input logic [CNT_W-1:0] c,
                                        input logic st);
    logic last;
    last = (c == LAST);
    next_state = s;
    case (s)
      ST_IDLE:  if (st)   next_state = ST_SHIFT;
      ST_SHIFT: if (last) next_state = ST_F1;
      ST_F1:    if (last) next_state = ST_F2;
      ST_F2:    if (last) next_state = ST_Y1;
      ST_Y1:    if (last) next_state = ST_Y2;
      ST_Y2:    if (last) next_state = ST_Y3;
      ST_Y3:    if (last) next_state = ST_DONE;
      ST_DONE:            next_state = ST_IDLE;
      default:            next_state = ST_IDLE;
    endcase
  endfunction

  // Hold counter: counts cycles within a step, zero outside steps.
  function automatic logic [CNT_W-1:0] next_cnt(input state_t s, input logic [CNT_W-1:0] c);
    next_cnt = '0;
    if (s != ST_IDLE && s != ST_DONE && c != LAST) begin
      next_cnt = c + CNT_W'(1);
    end
  endfunction

  // Output decode for a (state, count) pair; enables only on the last hold cycle.
  function automatic ctrl_t decode(input state_t s, input logic [CNT_W-1:0] c);
    ctrl_t o;
    logic  last;
    o    = '0;
    last = (c == LAST);
    o.busy = (s != ST_IDLE);
    case (s)
      ST_SHIFT: begin
        o.en3 = last;
        o.en4 = last;
      end
      ST_F1: begin
        o.mux_s = 3'd2; o.mux_c = 2'd0; o.mux_z = 2'd1;
        o.en2   = last;
      end
      ST_F2: begin
        o.mux_s = 3'd3; o.mux_c = 2'd1; o.mux_z = 2'd2;
        o.en2   = last;
      end
      ST_Y1: begin
        o.mux_s = 3'd1; o.mux_c = 2'd2; o.mux_z = 2'd0;
        o.en1   = last;
      end
      ST_Y2: begin
        o.mux_s = 3'd2; o.mux_c = 2'd3; o.mux_z = 2'd3;
        o.en1   = last;
      end
      ST_Y3: begin
        o.mux_s = 3'd3; o.mux_c = 2'd2; o.mux_z = 2'd3;
        o.en1   = last;
      end
      ST_DONE: o.done = 1'b1;
      default: o = '0;
    endcase
    decode = o;
  endfunction

  assign state_nx = next_state(state, cnt, start);
  assign cnt_nx   = next_cnt(state, cnt);

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ctrl_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ctrl_q    <= decode(state_nx, cnt_nx);
      overrun_q <= start && (state != ST_IDLE);
    end
  end

  assign busy    = ctrl_q.busy;
  assign done    = ctrl_q.done;
  assign overrun = overrun_q;
  assign muxS    = ctrl_q.mux_s;
  assign muxC    = ctrl_q.mux_c;
  assign muxZ    = ctrl_q.mux_z;
  assign en1     = ctrl_q.en1;
  assign en2     = ctrl_q.en2;
  assign en3     = ctrl_q.en3;
  assign en4     = ctrl_q.en4;

endmodule

// File: tb/tb_ctrl_filtro_pa200.sv
// Directed bench for ctrl_filtro_pa200: instance A (STEP_CYCLES=1) drives a
// Q8 behavioural datapath; instance B (STEP_CYCLES=3) checks hold timing.
module tb_ctrl_filtro_pa200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start_a, start_b;
  logic       busy_a, done_a, ovr_a, e1_a, e2_a, e3_a, e4_a;
  logic [2:0] s_a;
  logic [1:0] c_a, z_a;
  logic       busy_b, done_b, ovr_b, e1_b, e2_b, e3_b, e4_b;
  logic [2:0] s_b;
  logic [1:0] c_b, z_b;

  ctrl_filtro_pa200 #(.STEP_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .busy(busy_a), .done(done_a), .overrun(ovr_a),
    .muxS(s_a), .muxC(c_a), .muxZ(z_a),
    .en1(e1_a), .en2(e2_a), .en3(e3_a), .en4(e4_a)
  );

  ctrl_filtro_pa200 #(.STEP_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .busy(busy_b), .done(done_b), .overrun(ovr_b),
    .muxS(s_b), .muxC(c_b), .muxZ(z_b),
    .en1(e1_b), .en2(e2_b), .en3(e3_b), .en4(e4_b)
  );

  // {busy, done, overrun, muxS, muxC, muxZ, en1, en2, en3, en4}
  logic [13:0] vec_a, vec_b;
  assign vec_a = {busy_a, done_a, ovr_a, s_a, c_a, z_a, e1_a, e2_a, e3_a, e4_a};
  assign vec_b = {busy_b, done_b, ovr_b, s_b, c_b, z_b, e1_b, e2_b, e3_b, e4_b};

  localparam logic [13:0] STEP_V [6] = '{
    14'b1_0_0_000_00_00_0011,   // SHIFT
    14'b1_0_0_010_00_01_0100,   // F1
    14'b1_0_0_011_01_10_0100,   // F2
    14'b1_0_0_001_10_00_1000,   // Y1
    14'b1_0_0_010_11_11_1000,   // Y2
    14'b1_0_0_011_10_11_1000    // Y3
  };
  localparam logic [13:0] V_DONE = 14'b1_1_0_000_00_00_0000;
  localparam logic [13:0] V_OVR  = 14'b0_0_1_000_00_00_0000;
  localparam logic [13:0] EN_MASK = 14'h3FF0;

  // Q8 datapath: -a1=0.5, -a2=-0.25, b0=b2=1, b1=-2
  int uk, dp_y, dp_f, dp_f1, dp_f2, d1, cf, d3, mac;

  always_comb begin
    case (s_a)
      3'd0:    d1 = uk;
      3'd1:    d1 = dp_f;
      3'd2:    d1 = dp_f1;
      3'd3:    d1 = dp_f2;
      default: d1 = dp_y;
    endcase
    case (c_a)
      2'd0:    cf = 128;
      2'd1:    cf = -64;
      2'd2:    cf = 256;
      default: cf = -512;
    endcase
    case (z_a)
      2'd0:    d3 = 0;
      2'd1:    d3 = uk;
      2'd2:    d3 = dp_f;
      default: d3 = dp_y;
    endcase
    mac = ((d1 * cf) >>> 8) + d3;
  end

  always @(posedge clk) begin
    if (reset) begin
      dp_y <= 0; dp_f <= 0; dp_f1 <= 0; dp_f2 <= 0;
    end else begin
      if (e1_a) dp_y  <= mac;
      if (e2_a) dp_f  <= mac;
      if (e3_a) dp_f1 <= dp_f;
      if (e4_a) dp_f2 <= dp_f1;
    end
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // One sample on instance A; returns datapath f/y seen in the done cycle.
  task automatic run_sample(input int u, output int f_obs, output int y_obs);
    int n;
    uk = u;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (done_a !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("latency", n, 6);
    f_obs = dp_f;
    y_obs = dp_y;
    tick();
  endtask

  function automatic int q8(input int a, input int c);
    return (a * c) >>> 8;
  endfunction

  initial begin
    int f_o, y_o, rf, rf1, rf2, u, ry;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; uk = 0;
    repeat (3) tick();
    chk("reset_a", vec_a, 14'd0);
    chk("reset_b", vec_b, 14'd0);
    reset = 1'b0;
    tick();

    // Basic sequence, one cycle per step
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("seq_step%0d", i), vec_a, STEP_V[i]);
      tick();
    end
    chk("seq_done", vec_a, V_DONE);
    tick();
    chk("seq_idle", vec_a, 14'd0);

    // Hold timing, three cycles per step
    tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("hold_s%0d_c%0d", i, j), vec_b,
            (j == 2) ? STEP_V[i] : (STEP_V[i] & EN_MASK));
        tick();
      end
    end
    chk("hold_done", vec_b, V_DONE);
    tick();
    chk("hold_idle", vec_b, 14'd0);

    // Overrun: second start two cycles in, then a start during DONE
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("ovr_shift", vec_a, STEP_V[0]);
    tick();
    start_a = 1'b1;
    chk("ovr_f1", vec_a, STEP_V[1]);
    tick();
    start_a = 1'b0;
    chk("ovr_f2_pulse", vec_a, STEP_V[2] | V_OVR);
    for (int i = 3; i < 6; i++) begin
      tick();
      chk($sformatf("ovr_step%0d", i), vec_a, STEP_V[i]);
    end
    tick();
    chk("ovr_done", vec_a, V_DONE);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("ovr_in_done", vec_a, V_OVR);
    tick();
    chk("ovr_not_accepted", vec_a, 14'd0);
    tick();
    chk("ovr_still_idle", vec_a, 14'd0);

    // Reset held three cycles starting in Y2
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (4) tick();
    chk("mid_y2", vec_a, STEP_V[4]);
    reset = 1'b1;
    tick();
    chk("mid_reset", vec_a, 14'd0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("post_reset%0d", i), vec_a, 14'd0);
    end

    // Arithmetic from a cleared datapath
    run_sample(256, f_o, y_o);
    chk("arith_f1", f_o, 256);
    chk("arith_y1", y_o, 256);
    run_sample(0, f_o, y_o);
    chk("arith_f2", f_o, 128);
    chk("arith_y2", y_o, -384);

    // Back-to-back samples against the difference equations
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    rf = 0; rf1 = 0; rf2 = 0;
    for (int k = 0; k < 100; k++) begin
      u   = int'($urandom_range(2047, 0)) - 1024;
      rf2 = rf1;
      rf1 = rf;
      rf  = u + q8(rf1, 128) + q8(rf2, -64);
      ry  = q8(rf, 256) + q8(rf1, -512) + q8(rf2, 256);
      run_sample(u, f_o, y_o);
      chk($sformatf("b2b_f%0d", k), f_o, rf);
      chk($sformatf("b2b_y%0d", k), y_o, ry);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
